// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, capture FSM states and the output pixel record.
package vga_timing_pkg;

    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_H_DISP  = 640;
    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;
    localparam int VGA_V_DISP  = 480;
    localparam int VGA_V_TOTAL = 525;

    localparam int H_CNT_W = 11;
    localparam int L_CNT_W = 10;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} cap_state_t;

    typedef struct packed {
        logic       valid;
        logic [9:0] xpos;
        logic [9:0] ypos;
        logic [2:0] data;
        logic       fs;
    } pix_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Samples hs/vs and flags their edges; idle (high) after reset so no edge fires on release.
module vga_sync_edge (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic vga_hs,
    input  logic vga_vs,
    output logic hs_fall,
    output logic hs_rise,
    output logic vs_fall,
    output logic vs_rise
);

    logic hs_q, hs_d, vs_q, vs_d;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_q <= 1'b1;
            hs_d <= 1'b1;
            vs_q <= 1'b1;
            vs_d <= 1'b1;
        end else begin
            hs_q <= vga_hs;
            hs_d <= hs_q;
            vs_q <= vga_vs;
            vs_d <= vs_q;
        end
    end

    assign hs_fall = hs_d & ~hs_q;
    assign hs_rise = ~hs_d & hs_q;
    assign vs_fall = vs_d & ~vs_q;
    assign vs_rise = ~vs_d & vs_q;

endmodule

// File: rtl/vga_capture.sv
// Locks onto an incoming VGA stream, checks its timing every line and emits active pixels
// with their coordinates two clocks after they are sampled.
module vga_capture
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BACK  = VGA_H_BACK,
    parameter int H_DISP  = VGA_H_DISP,
    parameter int H_TOTAL = VGA_H_TOTAL,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BACK  = VGA_V_BACK,
    parameter int V_DISP  = VGA_V_DISP,
    parameter int V_TOTAL = VGA_V_TOTAL
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic [2:0] vga_rgb,
    output logic       pixel_valid,
    output logic [9:0] pixel_xpos,
    output logic [9:0] pixel_ypos,
    output logic [2:0] pixel_data,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [7:0] err_cnt
);

    localparam logic [H_CNT_W-1:0] H_LAST  = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] HS_LAST = H_CNT_W'(H_SYNC - 1);
    localparam logic [H_CNT_W-1:0] HA_LO   = H_CNT_W'(H_SYNC + H_BACK);
    localparam logic [H_CNT_W-1:0] HA_HI   = H_CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [L_CNT_W-1:0] V_LAST  = L_CNT_W'(V_TOTAL - 1);
    localparam logic [L_CNT_W-1:0] VS_LAST = L_CNT_W'(V_SYNC - 1);
    localparam logic [L_CNT_W-1:0] VA_LO   = L_CNT_W'(V_SYNC + V_BACK);
    localparam logic [L_CNT_W-1:0] VA_HI   = L_CNT_W'(V_SYNC + V_BACK + V_DISP);

    logic hs_fall, hs_rise, vs_fall, vs_rise;

    vga_sync_edge u_sync_edge (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .vga_hs   (vga_hs),
        .vga_vs   (vga_vs),
        .hs_fall  (hs_fall),
        .hs_rise  (hs_rise),
        .vs_fall  (vs_fall),
        .vs_rise  (vs_rise)
    );

    // h_cnt/l_cnt/rgb_d all describe the sample taken one clock earlier by the edge detector
    logic [2:0]         rgb_q, rgb_d;
    logic [H_CNT_W-1:0] h_cnt;
    logic [L_CNT_W-1:0] l_cnt;
    cap_state_t         state, state_nxt;
    logic               err_nxt;
    pix_t               pix_q;

    logic frame_edge, viol, active, cap;

    assign frame_edge = hs_fall & vs_fall;

    // A missing HFE looks like a line that runs past H_LAST; counters saturate so it fires once
    assign viol = (hs_fall ^ (h_cnt == H_LAST))
                | (hs_rise & (h_cnt != HS_LAST))
                | (vs_rise & (~hs_fall | (l_cnt != VS_LAST)))
                | (hs_fall & (frame_edge ^ (l_cnt == V_LAST)))
                | (vs_fall & ~hs_fall);

    assign active = (h_cnt >= HA_LO) && (h_cnt < HA_HI) && (l_cnt >= VA_LO) && (l_cnt < VA_HI);
    assign cap    = (state == LOCKED) && (state_nxt == LOCKED) && active;

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        unique case (state)
            SEARCH: if (frame_edge) state_nxt = CHECK;
            CHECK: begin
                if (viol) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end else if (frame_edge) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb_q      <= '0;
            rgb_d      <= '0;
            h_cnt      <= '0;
            l_cnt      <= '0;
            state      <= SEARCH;
            pix_q      <= '0;
            timing_err <= 1'b0;
            err_cnt    <= '0;
        end else begin
            rgb_q <= vga_rgb;
            rgb_d <= rgb_q;
            if (hs_fall)          h_cnt <= '0;
            else if (h_cnt != '1) h_cnt <= h_cnt + 1'b1;
            if (frame_edge)                  l_cnt <= '0;
            else if (hs_fall && l_cnt != '1) l_cnt <= l_cnt + 1'b1;
            state <= state_nxt;
            if (cap) begin
                pix_q.valid <= 1'b1;
                pix_q.xpos  <= 10'(h_cnt - HA_LO);
                pix_q.ypos  <= 10'(l_cnt - VA_LO);
                pix_q.data  <= rgb_d;
                pix_q.fs    <= (h_cnt == HA_LO) && (l_cnt == VA_LO);
            end else begin
                pix_q <= '0;
            end
            timing_err <= err_nxt;
            if (err_nxt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign pixel_valid = pix_q.valid;
    assign pixel_xpos  = pix_q.xpos;
    assign pixel_ypos  = pix_q.ypos;
    assign pixel_data  = pix_q.data;
    assign frame_start = pix_q.fs;
    assign locked      = (state == LOCKED);

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down raster (20 clocks x 10 lines per frame).
module tb_vga_capture;

    localparam int HS = 4, HB = 3, HD = 8, HT = 20;
    localparam int VS = 2, VB = 2, VD = 4, VT = 10;
    localparam int HA = HS + HB, VA = VS + VB;

    logic       vga_clk = 1'b0;
    logic       sys_rst_n, vga_hs, vga_vs;
    logic [2:0] vga_rgb;
    logic       pixel_valid, frame_start, locked, timing_err;
    logic [9:0] pixel_xpos, pixel_ypos;
    logic [2:0] pixel_data;
    logic [7:0] err_cnt;

    int n_assert = 0, n_fail = 0;
    int err_pulses = 0, vcnt = 0;
    bit saw_lock = 0, pix_chk = 0;
    logic [24:0] exp_q [2] = '{default: '0};

    vga_capture #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_TOTAL(VT)
    ) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_rgb(vga_rgb), .pixel_valid(pixel_valid), .pixel_xpos(pixel_xpos),
        .pixel_ypos(pixel_ypos), .pixel_data(pixel_data), .frame_start(frame_start),
        .locked(locked), .timing_err(timing_err), .err_cnt(err_cnt)
    );

    always #20 vga_clk = ~vga_clk;

    function automatic logic [63:0] outs();
        return {29'b0, pixel_valid, pixel_xpos, pixel_ypos, pixel_data, frame_start,
                locked, timing_err, err_cnt};
    endfunction

    function automatic logic [63:0] pix();
        return {39'b0, pixel_valid, pixel_xpos, pixel_ypos, pixel_data, frame_start};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One input clock; outputs seen here belong to the input driven two steps earlier
    task automatic step(input logic hs, input logic vs, input logic [2:0] rgb, input int n, input int l);
        logic [24:0] e;
        vga_hs = hs; vga_vs = vs; vga_rgb = rgb;
        @(posedge vga_clk); #1;
        if (timing_err) err_pulses++;
        if (locked) saw_lock = 1;
        if (pixel_valid) vcnt++;
        e = '0;
        if (pix_chk && n >= HA && n < HA + HD && l >= VA && l < VA + VD)
            e = {1'b1, 10'(n - HA), 10'(l - VA), rgb, 1'(n == HA && l == VA)};
        if (pix_chk) check("pixel", pix(), {39'b0, exp_q[1]});
        exp_q[1] = exp_q[0];
        exp_q[0] = e;
    endtask

    task automatic gen_frame(input int l0, input int l1, input int short_l, input bit chk,
                             input bit marker, input bit lock_edge);
        logic [2:0] rv;
        int len;
        pix_chk = chk;
        for (int l = l0; l < l1; l++) begin
            len = (l == short_l) ? HT - 1 : HT;
            for (int n = 0; n < len; n++) begin
                if (marker)
                    rv = (n == HA && l == VA) ? 3'b101 :
                         (n == HA + HD - 1 && l == VA + VD - 1) ? 3'b011 : 3'b000;
                else
                    rv = 3'((n * 5 + l * 3) % 8);
                step(n >= HS, l >= VS, rv, n, l);
                if (lock_edge && l == 0 && n == 0) check("lock_before", 64'(locked), 64'd0);
                if (lock_edge && l == 0 && n == 1) check("lock_rise", 64'(locked), 64'd1);
                if (marker && l == VA && n == HA + 2)
                    check("first_px", pix(), {39'b0, 1'b1, 10'd0, 10'd0, 3'b101, 1'b1});
                if (marker && l == VA + VD - 1 && n == HA + HD + 1)
                    check("last_px", pix(), {39'b0, 1'b1, 10'(HD - 1), 10'(VD - 1), 3'b011, 1'b0});
                if (short_l >= 0 && l == short_l + 1 && n == 0)
                    check("short_pre", {62'b0, locked, timing_err}, 64'b10);
                if (short_l >= 0 && l == short_l + 1 && n == 1)
                    check("short_err", {54'b0, locked, timing_err, err_cnt}, {54'b0, 2'b01, 8'd1});
            end
        end
        pix_chk = 0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        repeat (3) step(1'b1, 1'b1, 3'b111, 0, 0);
        check("reset_state", outs(), 64'd0);
        sys_rst_n = 1'b1;

        // clean start: lock one cycle after the second frame edge, no errors
        gen_frame(0, VT, -1, 0, 0, 0);
        check("no_lock_1st_frame", 64'(saw_lock), 64'd0);
        vcnt = 0;
        gen_frame(0, VT, -1, 1, 0, 1);
        check("valid_count_f2", 64'(vcnt), 64'(HD * VD));
        vcnt = 0;
        gen_frame(0, VT, -1, 1, 1, 0);
        check("valid_count_marker", 64'(vcnt), 64'(HD * VD));
        check("clean_no_err", {32'(err_pulses), 32'(err_cnt)}, 64'd0);

        // one short line while locked, then relock
        gen_frame(0, VT, 5, 0, 0, 0);
        gen_frame(0, VT, -1, 0, 0, 0);
        gen_frame(0, VT, -1, 1, 0, 1);
        check("short_single_pulse", 64'(err_pulses), 64'd1);

        // hs stuck high while locked
        gen_frame(0, 3, -1, 0, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 1'b1, 3'b000, 0, 0);
            if (i == 0) check("hold_pre", 64'(timing_err), 64'd0);
            if (i == 1) check("hold_err", {62'b0, locked, timing_err}, 64'b01);
        end
        check("hold_single_pulse", 64'(err_pulses), 64'd2);
        gen_frame(0, VT, -1, 0, 0, 0);
        gen_frame(0, VT, -1, 0, 0, 1);
        check("hold_errcnt", 64'(err_cnt), 64'd2);

        // reset mid-frame while locked
        gen_frame(0, 5, -1, 0, 0, 0);
        saw_lock = 0;
        for (int n = 0; n < HT; n++) begin
            sys_rst_n = (n >= 10);
            step(n >= HS, 1'b1, 3'b110, n, 5);
            if (n < 10) check("in_reset", outs(), 64'd0);
        end
        gen_frame(6, VT, -1, 0, 0, 0);
        gen_frame(0, VT, -1, 0, 0, 0);
        check("no_lock_after_rst", 64'(saw_lock), 64'd0);
        gen_frame(0, VT, -1, 0, 0, 1);
        check("rst_errcnt", 64'(err_cnt), 64'd0);

        // repeated forced violations saturate err_cnt
        sys_rst_n = 1'b0;
        step(1'b1, 1'b1, 3'b000, 0, 0);
        sys_rst_n = 1'b1;
        err_pulses = 0;
        for (int k = 1; k <= 320; k++) begin
            for (int n = 0; n < 10; n++) step(n >= HS, 1'b0, 3'b000, 0, 0);
            for (int n = 0; n < 10; n++) step(n >= HS, 1'b1, 3'b000, 0, 0);
            if (k == 100) check("errcnt_100", 64'(err_cnt), 64'd100);
            if (k == 255) check("errcnt_255", 64'(err_cnt), 64'd255);
            if (k == 300) check("errcnt_300", 64'(err_cnt), 64'd255);
        end
        check("errcnt_hold", {32'(err_pulses), 32'(err_cnt)}, {32'd320, 32'd255});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
